instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one word read at a time and buffers up to two
// fetched {inst, pc} pairs for the control unit, with redirect flushing.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [1:0]  dbg_state,
    output logic [1:0]  dbg_count
);

    // Handshakes: a memory beat completes when mem_req && mem_ack in the same
    // cycle; an instruction is consumed when inst_valid && inst_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DISCARD = 2'd2} state_t;

    state_t      state, state_next;
    logic [15:0] fetch_pc, fetch_pc_next, mem_addr_next;
    logic [15:0] head_inst, head_pc, tail_inst, tail_pc;
    logic [1:0]  count, count_next;
    logic        push, pop, wr_tail;

    assign mem_req    = (state != IDLE);
    assign inst_valid = (count != 2'd0);
    assign inst       = head_inst;
    assign inst_pc    = head_pc;
    assign dbg_state  = state;
    assign dbg_count  = count;

    // Redirect wins over both push and pop.
    assign pop     = inst_valid && inst_ready && !redirect;
    assign push    = (state == BUSY) && mem_ack && !redirect;
    assign wr_tail = (count == 2'd1) && !pop;

    always_comb begin
        count_next = count;
        if (redirect)
            count_next = 2'd0;
        else if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    always_comb begin
        state_next    = state;
        mem_addr_next = mem_addr;
        fetch_pc_next = redirect ? redirect_pc : fetch_pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_next    = BUSY;
                    mem_addr_next = redirect_pc;
                end else if (count_next < 2'd2) begin
                    state_next    = BUSY;
                    mem_addr_next = fetch_pc;
                end
            end
            BUSY: begin
                if (redirect) begin
                    if (mem_ack)
                        mem_addr_next = redirect_pc;
                    else
                        state_next = DISCARD;
                end else if (mem_ack) begin
                    fetch_pc_next = mem_addr + 16'd1;
                    if (count_next < 2'd2)
                        mem_addr_next = mem_addr + 16'd1;
                    else
                        state_next = IDLE;
                end
            end
            DISCARD: begin
                // The returning word belongs to the stale stream and is dropped.
                if (mem_ack) begin
                    state_next    = BUSY;
                    mem_addr_next = redirect ? redirect_pc : fetch_pc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            count    <= 2'd0;
        end else begin
            state    <= state_next;
            mem_addr <= mem_addr_next;
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_inst <= 16'h0000;
            head_pc   <= 16'h0000;
            tail_inst <= 16'h0000;
            tail_pc   <= 16'h0000;
        end else if (!redirect) begin
            if (pop) begin
                head_inst <= tail_inst;
                head_pc   <= tail_pc;
            end
            // Placed after the shift so a push into an emptied head wins.
            if (push) begin
                if (wr_tail) begin
                    tail_inst <= mem_rdata;
                    tail_pc   <= mem_addr;
                end else begin
                    head_inst <= mem_rdata;
                    head_pc   <= mem_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a streaming/backpressure vector table
// followed by hand sequences for slow memory, redirects, wrap and reset.
module tb_instr_fetch_unit;

    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DISCARD = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    always #5 clk = ~clk;

    // ROM contents: word a holds a ^ 16'hA5A5.
    assign mem_rdata = mem_addr ^ 16'hA5A5;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_head(input string name, input logic [15:0] pc);
        chk({name, "_valid"}, {15'd0, inst_valid}, 16'd1);
        chk({name, "_pc"}, inst_pc, pc);
        chk({name, "_inst"}, inst, rom(pc));
    endtask

    // A push must never land on a full buffer.
    always @(negedge clk) begin
        #3;
        if (reset && dbg_state == S_BUSY && mem_ack && !redirect)
            chk("push_at_full", {15'd0, dbg_count == 2'd2}, 16'd0);
    end

    typedef struct {
        logic        ack;
        logic        ready;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        chk_addr;
        logic        exp_valid;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic ack, input logic ready, input logic req,
                                input logic [15:0] addr, input logic ca,
                                input logic valid, input logic [15:0] pc);
        vec_t v;
        v.ack = ack; v.ready = ready; v.exp_req = req; v.exp_addr = addr;
        v.chk_addr = ca; v.exp_valid = valid; v.exp_pc = pc;
        return v;
    endfunction

    initial begin
        // Streaming from reset, then 10 cycles of backpressure, then release.
        vecs[0]  = mk(1, 1, 0, 16'd0, 1, 0, 16'd0);
        vecs[1]  = mk(1, 1, 1, 16'd0, 1, 0, 16'd0);
        vecs[2]  = mk(1, 1, 1, 16'd1, 1, 1, 16'd0);
        vecs[3]  = mk(1, 1, 1, 16'd2, 1, 1, 16'd1);
        vecs[4]  = mk(1, 1, 1, 16'd3, 1, 1, 16'd2);
        vecs[5]  = mk(1, 0, 1, 16'd4, 1, 1, 16'd3);
        for (int i = 6; i < 15; i++) vecs[i] = mk(1, 0, 0, 16'd0, 0, 1, 16'd3);
        vecs[15] = mk(1, 1, 0, 16'd0, 0, 1, 16'd3);
        vecs[16] = mk(1, 1, 1, 16'd5, 1, 1, 16'd4);
        vecs[17] = mk(1, 1, 1, 16'd6, 1, 1, 16'd5);
        vecs[18] = mk(0, 1, 1, 16'd7, 1, 1, 16'd6);
        vecs[19] = mk(0, 0, 1, 16'd7, 1, 0, 16'd0);

        reset = 1'b0; mem_ack = 1'b0; redirect = 1'b0; redirect_pc = 16'd0; inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {15'd0, mem_req}, 16'd0);
        chk("rst_addr", mem_addr, 16'd0);
        chk("rst_valid", {15'd0, inst_valid}, 16'd0);
        chk("rst_inst", inst, 16'd0);
        chk("rst_pc", inst_pc, 16'd0);
        chk("rst_state", {14'd0, dbg_state}, {14'd0, S_IDLE});
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            mem_ack = vecs[i].ack;
            inst_ready = vecs[i].ready;
            chk($sformatf("vec%0d_req", i), {15'd0, mem_req}, {15'd0, vecs[i].exp_req});
            if (vecs[i].chk_addr) chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), {15'd0, inst_valid}, {15'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), inst_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d_inst", i), inst, rom(vecs[i].exp_pc));
            end
            step();
        end

        // Slow memory: request at 7 waits three cycles before the ack.
        for (int i = 0; i < 3; i++) begin
            chk("slow_req", {15'd0, mem_req}, 16'd1);
            chk("slow_addr", mem_addr, 16'd7);
            chk("slow_valid", {15'd0, inst_valid}, 16'd0);
            step();
        end
        mem_ack = 1'b1;
        chk("slow_ack_addr", mem_addr, 16'd7);
        step();
        mem_ack = 1'b0; inst_ready = 1'b1;
        chk_head("slow_out", 16'd7);
        chk("slow_next_addr", mem_addr, 16'd8);
        step();

        // Redirect coinciding with an ack drops that word and reissues at 5.
        redirect = 1'b1; redirect_pc = 16'd5; mem_ack = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 16'd61; mem_ack = 1'b0;
        chk("rd_ack_addr", mem_addr, 16'd5);
        chk("rd_ack_valid", {15'd0, inst_valid}, 16'd0);
        chk("rd_ack_state", {14'd0, dbg_state}, {14'd0, S_BUSY});
        step();
        // Redirect to 61 while 5 is pending: request kept at old address.
        redirect = 1'b0;
        chk("rd_disc_state", {14'd0, dbg_state}, {14'd0, S_DISCARD});
        chk("rd_disc_req", {15'd0, mem_req}, 16'd1);
        chk("rd_disc_addr", mem_addr, 16'd5);
        step();
        mem_ack = 1'b1;
        chk("rd_disc_hold", mem_addr, 16'd5);
        step();
        chk("rd_new_addr", mem_addr, 16'd61);
        chk("rd_dropped", {15'd0, inst_valid}, 16'd0);
        step();
        mem_ack = 1'b0;
        chk_head("rd_first", 16'd61);
        step();

        // Wrap: redirect in DISCARD retargets to 16'hFFFF.
        redirect = 1'b1; redirect_pc = 16'd100;
        step();
        redirect_pc = 16'hFFFF;
        chk("wrap_disc_state", {14'd0, dbg_state}, {14'd0, S_DISCARD});
        chk("wrap_disc_addr", mem_addr, 16'd62);
        step();
        redirect = 1'b0; mem_ack = 1'b1;
        step();
        chk("wrap_addr", mem_addr, 16'hFFFF);
        chk("wrap_empty", {15'd0, inst_valid}, 16'd0);
        step();
        chk_head("wrap_ffff", 16'hFFFF);
        chk("wrap_addr0", mem_addr, 16'h0000);
        step();
        mem_ack = 1'b0;
        chk_head("wrap_0000", 16'h0000);
        step();

        // Redirect in IDLE with a full buffer: flush, pop ignored, issue at target.
        inst_ready = 1'b0; mem_ack = 1'b1;
        step();
        step();
        mem_ack = 1'b0;
        chk("idle_state", {14'd0, dbg_state}, {14'd0, S_IDLE});
        chk("idle_req", {15'd0, mem_req}, 16'd0);
        chk("idle_count", {14'd0, dbg_count}, 16'd2);
        chk_head("idle_head", 16'd1);
        redirect = 1'b1; redirect_pc = 16'h1234; inst_ready = 1'b1;
        step();
        redirect = 1'b0; mem_ack = 1'b1;
        chk("idle_rd_req", {15'd0, mem_req}, 16'd1);
        chk("idle_rd_addr", mem_addr, 16'h1234);
        chk("idle_rd_flush", {15'd0, inst_valid}, 16'd0);
        step();
        mem_ack = 1'b0; inst_ready = 1'b0;
        chk_head("idle_rd_out", 16'h1234);

        // Reset asserted mid-request forces reset values at once.
        #2 reset = 1'b0;
        #1;
        chk("mrst_req", {15'd0, mem_req}, 16'd0);
        chk("mrst_addr", mem_addr, 16'd0);
        chk("mrst_valid", {15'd0, inst_valid}, 16'd0);
        chk("mrst_inst", inst, 16'd0);
        chk("mrst_pc", inst_pc, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1; inst_ready = 1'b1;
        step();
        chk("mrst_req_again", {15'd0, mem_req}, 16'd1);
        chk("mrst_addr_again", mem_addr, 16'd0);
        step();
        chk_head("mrst_first", 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
